// File: rtl/red_d_pkg.sv
// Shared Dilithium coefficient types and constants for the red_d datapath
// (multiplier producer, Barrett reduction consumer and their benches).
package red_d_pkg;

    localparam int unsigned Q     = 8380417;
    localparam int unsigned W_OP  = 23;
    localparam int unsigned W_PR  = 2 * W_OP;
    localparam int unsigned W_CNT = 16;

    typedef logic [W_OP-1:0] coef_t;
    typedef logic [W_PR-1:0] prod_t;

    // True when a coefficient is a canonical residue, i.e. strictly below Q.
    function automatic logic in_range(input coef_t x);
        return {9'd0, x} < Q;
    endfunction

endpackage

// File: rtl/pipe_reg_vr.sv
// One valid/ready pipeline register stage. Refills in the same cycle it drains,
// so a chain of these sustains one transfer per cycle; stalled data holds.
module pipe_reg_vr #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ready_i
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             load;

    // Ready depends only on local state and downstream ready, never on valid_i.
    assign ready_o = !valid_q || ready_i;
    assign load    = valid_i && ready_o;

    // NOTE: every always_comb target gets a default first, so no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state updates use non-blocking assignments; the data register is reset
    // too because its value is visible on product_o and must read 0 after reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mul_d_pipe.sv
// Two-stage pipelined 23x23 unsigned multiplier feeding red_d.product_i.
// Optional sticky operand range check enabled by defining MUL_D_RANGE_CHK_EN.
module mul_d_pipe
    import red_d_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [W_OP-1:0]   a_i,
    input  logic [W_OP-1:0]   b_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [W_PR-1:0]   product_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [W_CNT-1:0]  cnt_o,
    output logic              err_o
);

    logic              s1_valid;
    logic [2*W_OP-1:0] s1_data;
    logic              s2_ready;
    coef_t             s1_a, s1_b;
    prod_t             mult;
    logic              in_xfer;

    pipe_reg_vr #(.WIDTH(2 * W_OP)) u_s1 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .valid_i (valid_i),
        .data_i  ({a_i, b_i}),
        .ready_o (ready_o),
        .valid_o (s1_valid),
        .data_o  (s1_data),
        .ready_i (s2_ready)
    );

    assign s1_a = s1_data[2*W_OP-1:W_OP];
    assign s1_b = s1_data[W_OP-1:0];
    assign mult = prod_t'(s1_a) * prod_t'(s1_b);

    pipe_reg_vr #(.WIDTH(W_PR)) u_s2 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .valid_i (s1_valid),
        .data_i  (mult),
        .ready_o (s2_ready),
        .valid_o (valid_o),
        .data_o  (product_o),
        .ready_i (ready_i)
    );

    assign in_xfer = valid_i && ready_o;

    logic [W_CNT-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (in_xfer) begin
            cnt_d = cnt_q + W_CNT'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

`ifdef MUL_D_RANGE_CHK_EN
    logic err_q, err_d;

    // Out-of-range operands are flagged but still multiplied and delivered.
    always_comb begin
        err_d = err_q;
        if (in_xfer && (!in_range(a_i) || !in_range(b_i))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mul_d_pipe.sv
// Scoreboard bench for mul_d_pipe: the driver queues expected products on each
// accepted input, a negedge monitor pops and compares on each output transfer.
module tb_mul_d_pipe;
    import red_d_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    coef_t            a = '0;
    coef_t            b = '0;
    logic             vi = 1'b0;
    logic             ri = 1'b0;
    logic             ro;
    logic             vo;
    prod_t            po;
    logic [W_CNT-1:0] cnt;
    logic             err;

    int    checks = 0;
    int    errors = 0;
    prod_t exp_q[$];

`ifdef MUL_D_RANGE_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    mul_d_pipe dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .a_i       (a),
        .b_i       (b),
        .valid_i   (vi),
        .ready_o   (ro),
        .product_o (po),
        .valid_o   (vo),
        .ready_i   (ri),
        .cnt_o     (cnt),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: an output transfer happens at the next rising edge when valid_o && ready_i.
    always @(negedge clk) begin
        if (rst_n && vo && ri) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got product %0d, expected no output", po);
            end else begin
                check("product", 64'(po), 64'(exp_q.pop_front()));
            end
        end
    end

    // One clock of stimulus; inputs change 2 units after the rising edge.
    task automatic cycle(input coef_t ta, input coef_t tb_v, input logic tv, input logic tr,
                         input prod_t texp, output logic acc);
        a  = ta;
        b  = tb_v;
        vi = tv;
        ri = tr;
        @(negedge clk);
        acc = tv && ro;
        if (acc) exp_q.push_back(texp);
        @(posedge clk);
        #2;
    endtask

    task automatic send(input coef_t ta, input coef_t tb_v, input prod_t texp);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            cycle(ta, tb_v, 1'b1, 1'b1, texp, acc);
            n++;
        end
        if (!acc) check("send_accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle('0, '0, 1'b0, 1'b1, '0, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            idle(1);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   acc_n;

        // Reset held, then released.
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid_o", 64'(vo), 64'd0);
        check("rst_ready_o", 64'(ro), 64'd1);
        check("rst_product_o", 64'(po), 64'd0);
        check("rst_cnt_o", 64'(cnt), 64'd0);
        check("rst_err_o", 64'(err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("post_rst_ready_o", 64'(ro), 64'd1);
        check("post_rst_valid_o", 64'(vo), 64'd0);

        // Single op (Q-1)^2 with a latency check.
        cycle(coef_t'(Q - 1), coef_t'(Q - 1), 1'b1, 1'b1, prod_t'(46'd70231372333056), acc);
        check("single_accept", 64'(acc), 64'd1);
        vi = 1'b0;
        @(negedge clk);
        check("latency_1_valid_o", 64'(vo), 64'd0);
        @(posedge clk);
        #2;
        @(negedge clk);
        check("latency_2_valid_o", 64'(vo), 64'd1);
        @(posedge clk);
        #2;
        check("single_err_o", 64'(err), 64'd0);
        check("single_cnt_o", 64'(cnt), 64'd1);

        // Boundary operands.
        send(23'h7FFFFF, 23'h7FFFFF, prod_t'(46'd70368727400449));
        send(23'd0, 23'h7FFFFF, prod_t'(46'd0));
        send(23'd1, 23'd1, prod_t'(46'd1));
        drain();
        check("boundary_cnt_o", 64'(cnt), 64'd4);

        // 50 back-to-back ops.
        acc_n = 0;
        for (int i = 0; i < 50; i++) begin
            coef_t sa, sb;
            sa = coef_t'(i * 167117 + 3);
            sb = coef_t'(8388607 - i * 99991);
            cycle(sa, sb, 1'b1, 1'b1, prod_t'(64'(sa) * 64'(sb)), acc);
            if (acc) acc_n++;
        end
        check("stream_accepted", 64'(acc_n), 64'd50);
        drain();
        check("stream_cnt_o", 64'(cnt), 64'd54);

        // Backpressure: two accepts fill the pipe, then five stalled cycles.
        cycle(23'd100, 23'd200, 1'b1, 1'b0, prod_t'(46'd20000), acc);
        check("bp_accept_1", 64'(acc), 64'd1);
        cycle(23'd150, 23'd400, 1'b1, 1'b0, prod_t'(46'd60000), acc);
        check("bp_accept_2", 64'(acc), 64'd1);
        a  = 23'd300;
        b  = 23'd400;
        vi = 1'b1;
        ri = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ready_o", 64'(ro), 64'd0);
            check("bp_valid_o", 64'(vo), 64'd1);
            check("bp_product_stable", 64'(po), 64'd20000);
            @(posedge clk);
            #2;
        end
        send(23'd300, 23'd400, prod_t'(46'd120000));
        send(23'd5, 23'd7, prod_t'(46'd35));
        drain();
        check("bp_cnt_o", 64'(cnt), 64'd58);

        // Range check: Q itself is out of range; the product is still delivered.
        send(coef_t'(Q), 23'd1, prod_t'(Q));
        check("range_err_set", 64'(err), 64'(EXP_ERR));
        send(23'd2, 23'd3, prod_t'(46'd6));
        drain();
        check("range_err_sticky", 64'(err), 64'(EXP_ERR));

        // Mid-operation reset with two ops in flight.
        cycle(23'd11, 23'd13, 1'b1, 1'b1, prod_t'(46'd143), acc);
        cycle(23'd17, 23'd19, 1'b1, 1'b1, prod_t'(46'd323), acc);
        vi = 1'b0;
        check("midrst_pre_valid_o", 64'(vo), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid_o", 64'(vo), 64'd0);
        check("midrst_ready_o", 64'(ro), 64'd1);
        check("midrst_product_o", 64'(po), 64'd0);
        check("midrst_cnt_o", 64'(cnt), 64'd0);
        check("midrst_err_o", 64'(err), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(6);
        check("midrst_no_stale", 64'(vo), 64'd0);

        // Counter wrap.
        acc_n = 0;
        for (int i = 0; i < 65535; i++) begin
            cycle(coef_t'(i), 23'd3, 1'b1, 1'b1, prod_t'(3 * i), acc);
            if (acc) acc_n++;
        end
        check("wrap_accepted", 64'(acc_n), 64'd65535);
        check("wrap_cnt_max", 64'(cnt), 64'd65535);
        send(23'd9, 23'd9, prod_t'(46'd81));
        check("wrap_cnt_zero", 64'(cnt), 64'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
